// File: rtl/fp_result_out_ctrl.sv
// Output-side controller for the FP multiplier. It captures products, classifies them, and
// buffers them behind an output register that is presented on a valid/ready handshake.
module fp_result_out_ctrl #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mul_valid,
  input  logic [W-1:0]  mul_result,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [W-1:0]  dout_data,
  output logic [3:0]    dout_flags,
  output logic          res_full,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  input  logic          ovf_clear,
  output logic [15:0]   delivered_cnt
);

  localparam logic [0:0]  EMPTY    = 1'b0;
  localparam logic [0:0]  HOLD     = 1'b1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  // Flags are {nan, inf, zero, subnormal}. The sign bit does not affect the class.
  function automatic logic [3:0] classify(input logic [W-1:0] word);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = word[W-2 -: EXP_W];
    m = word[MAN_W-1:0];
    classify = {(&e) & (|m), (&e) & ~(|m), ~(|e) & ~(|m), ~(|e) & (|m)};
  endfunction

  logic [0:0]      state;
  logic [W+3:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count_next;
  logic            pop, load_slot, fifo_rd, bypass, fifo_wr, drop;

  // Every load decision is made in one place, so the output register always holds the oldest word.
  always_comb begin
    pop        = (state == HOLD) && dout_ready;
    load_slot  = (state == EMPTY) || pop;
    fifo_rd    = load_slot && (fifo_count != '0);
    bypass     = load_slot && (fifo_count == '0) && mul_valid;
    drop       = mul_valid && !bypass && (fifo_count == FULL_CNT) && !fifo_rd;
    fifo_wr    = mul_valid && !bypass && !drop;
    count_next = fifo_count;
    if (fifo_wr && !fifo_rd)      count_next = fifo_count + 1'b1;
    else if (fifo_rd && !fifo_wr) count_next = fifo_count - 1'b1;
  end

  // NOTE: the storage array is not reset. The pointers and the count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {mul_result, classify(mul_result)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= EMPTY;
      dout_data     <= '0;
      dout_flags    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      res_full      <= 1'b0;
      overflow      <= 1'b0;
      delivered_cnt <= '0;
    end else begin
      if (load_slot) begin
        if (fifo_rd) begin
          {dout_data, dout_flags} <= mem[rd_ptr];
          state                   <= HOLD;
        end else if (bypass) begin
          dout_data  <= mul_result;
          dout_flags <= classify(mul_result);
          state      <= HOLD;
        end else begin
          state <= EMPTY;
        end
      end
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
      res_full   <= (count_next == FULL_CNT);
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
      if (pop) delivered_cnt <= delivered_cnt + 16'd1;
    end
  end

  assign dout_valid = (state == HOLD);

endmodule

// File: tb/tb_fp_result_out_ctrl.sv
// Directed testbench for fp_result_out_ctrl. Each scenario task does its own comparisons
// against hand-computed expected values.
module tb_fp_result_out_ctrl;

  logic        clk = 1'b0;
  logic        reset, mul_valid, dout_ready, ovf_clear;
  logic [31:0] mul_result, dout_data;
  logic        dout_valid, res_full, overflow;
  logic [3:0]  dout_flags;
  logic [2:0]  fifo_count;
  logic [15:0] delivered_cnt;
  int          errors = 0;
  int          checks = 0;

  fp_result_out_ctrl dut (
    .clk(clk), .reset(reset), .mul_valid(mul_valid), .mul_result(mul_result),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_flags(dout_flags), .res_full(res_full), .fifo_count(fifo_count),
    .overflow(overflow), .ovf_clear(ovf_clear), .delivered_cnt(delivered_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mul_valid = 1'b0; mul_result = '0; dout_ready = 1'b0; ovf_clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({dout_valid, dout_data, dout_flags, res_full, fifo_count, overflow, delivered_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h flags=%b full=%b count=%0d ovf=%b dlv=%0d, want all zero",
               dout_valid, dout_data, dout_flags, res_full, fifo_count, overflow, delivered_cnt);
    end
  endtask

  task automatic test_single();
    mul_valid = 1'b1; mul_result = 32'h40490FDB; dout_ready = 1'b1;
    tick();
    mul_valid = 1'b0;
    checks++;
    if ({dout_valid, dout_data, dout_flags} !== {1'b1, 32'h40490FDB, 4'b0000}) begin
      errors++;
      $display("FAIL single_load: valid=%b data=%h flags=%b, want 1 40490fdb 0000", dout_valid, dout_data, dout_flags);
    end
    tick();
    checks++;
    if ({dout_valid, delivered_cnt} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL single_transfer: valid=%b dlv=%0d, want 0 1", dout_valid, delivered_cnt);
    end
  endtask

  task automatic test_classify_fill();
    logic [31:0] w [5] = '{32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h00000001, 32'h3F800000};
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mul_valid = 1'b1; mul_result = w[i];
      tick();
    end
    mul_valid = 1'b0;
    checks++;
    if ({dout_valid, dout_data, dout_flags} !== {1'b1, 32'h7F800000, 4'b0100}) begin
      errors++;
      $display("FAIL fill_head: valid=%b data=%h flags=%b, want 1 7f800000 0100", dout_valid, dout_data, dout_flags);
    end
    checks++;
    if ({fifo_count, res_full, overflow} !== {3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fill_status: count=%0d full=%b ovf=%b, want 4 1 0", fifo_count, res_full, overflow);
    end
  endtask

  task automatic test_drop_drain();
    logic [31:0] w [5] = '{32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h00000001, 32'h3F800000};
    logic [3:0]  f [5] = '{4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b0000};
    // A drop and a clear in the same cycle must leave overflow set.
    mul_valid = 1'b1; mul_result = 32'hBF800000; ovf_clear = 1'b1;
    tick();
    mul_valid = 1'b0; ovf_clear = 1'b0;
    checks++;
    if ({overflow, fifo_count, dout_data} !== {1'b1, 3'd4, 32'h7F800000}) begin
      errors++;
      $display("FAIL drop: ovf=%b count=%0d data=%h, want 1 4 7f800000", overflow, fifo_count, dout_data);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({dout_valid, dout_data, dout_flags} !== {1'b1, w[i], f[i]}) begin
        errors++;
        $display("FAIL drain_%0d: valid=%b data=%h flags=%b, want 1 %h %b", i, dout_valid, dout_data, dout_flags, w[i], f[i]);
      end
      tick();
    end
    checks++;
    if ({dout_valid, fifo_count, res_full, overflow, delivered_cnt} !== {1'b0, 3'd0, 1'b0, 1'b1, 16'd6}) begin
      errors++;
      $display("FAIL drain_end: valid=%b count=%0d full=%b ovf=%b dlv=%0d, want 0 0 0 1 6",
               dout_valid, fifo_count, res_full, overflow, delivered_cnt);
    end
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b, want 0", overflow);
    end
  endtask

  task automatic test_full_pop_write();
    logic [31:0] w [6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mul_valid = 1'b1; mul_result = w[i];
      tick();
    end
    mul_valid = 1'b1; mul_result = w[5]; dout_ready = 1'b1;
    tick();
    mul_valid = 1'b0;
    checks++;
    if ({fifo_count, overflow, dout_data} !== {3'd4, 1'b0, w[1]}) begin
      errors++;
      $display("FAIL full_pop_write: count=%0d ovf=%b data=%h, want 4 0 %h", fifo_count, overflow, dout_data, w[1]);
    end
    for (int i = 1; i < 6; i++) begin
      checks++;
      if ({dout_valid, dout_data} !== {1'b1, w[i]}) begin
        errors++;
        $display("FAIL order_%0d: valid=%b data=%h, want 1 %h", i, dout_valid, dout_data, w[i]);
      end
      tick();
    end
    checks++;
    if ({dout_valid, fifo_count, delivered_cnt} !== {1'b0, 3'd0, 16'd12}) begin
      errors++;
      $display("FAIL full_end: valid=%b count=%0d dlv=%0d, want 0 0 12", dout_valid, fifo_count, delivered_cnt);
    end
  endtask

  task automatic test_back_to_back();
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mul_valid = 1'b1; mul_result = 32'h41000000 + 32'(i);
      tick();
      checks++;
      if ({dout_valid, dout_data, fifo_count} !== {1'b1, 32'h41000000 + 32'(i), 3'd0}) begin
        errors++;
        $display("FAIL b2b_%0d: valid=%b data=%h count=%0d, want 1 %h 0", i, dout_valid, dout_data, fifo_count,
                 32'h41000000 + 32'(i));
      end
    end
    mul_valid = 1'b0;
    tick();
    checks++;
    if ({dout_valid, delivered_cnt} !== {1'b0, 16'd18}) begin
      errors++;
      $display("FAIL b2b_end: valid=%b dlv=%0d, want 0 18", dout_valid, delivered_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mul_valid = 1'b1; mul_result = 32'h42000000 + 32'(i);
      tick();
    end
    mul_valid = 1'b0;
    checks++;
    if ({dout_valid, fifo_count} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL pre_reset: valid=%b count=%0d, want 1 3", dout_valid, fifo_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({dout_valid, dout_data, fifo_count, res_full, overflow, delivered_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h count=%0d full=%b ovf=%b dlv=%0d, want all zero",
               dout_valid, dout_data, fifo_count, res_full, overflow, delivered_cnt);
    end
    tick();
    checks++;
    if ({dout_valid, fifo_count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL post_reset_idle: valid=%b count=%0d, want 0 0", dout_valid, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_classify_fill();
    test_drop_drain();
    test_full_pop_write();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
